// File: rtl/riscv_pkg.sv
// Shared RISC-V constants and fetch-side types: NOP, base opcodes, PCSrc
// encodings, fetch FSM states and the layout of one instruction-queue entry.
package riscv_pkg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_ALUI  = 7'b0010011;
    localparam logic [6:0] OP_JALR  = 7'b1100111;
    localparam logic [6:0] OP_STORE = 7'b0100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;

    typedef enum logic [1:0] {
        PCSRC_SEQ  = 2'b00,
        PCSRC_IMM  = 2'b01,
        PCSRC_JALR = 2'b10
    } pcsrc_t;

    typedef enum logic {
        FETCH = 1'b0,
        DRAIN = 1'b1
    } fetch_state_t;

    // One queue entry: instruction word in the upper half, its PC in the lower.
    typedef struct packed {
        logic [31:0] inst;
        logic [31:0] pc;
    } fetch_entry_t;

    // Fetch addresses are always word aligned; the low two bits are dropped.
    function automatic logic [31:0] word_align(input logic [31:0] addr);
        return {addr[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/inst_fifo.sv
// Small synchronous FIFO holding fetched {inst, pc} pairs for decode.
// Flush empties the queue in one cycle and wins over push and pop.
module inst_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64,
    localparam int CNT_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign head    = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; only this control state is reset.
    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // Entry storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: issues word reads to instruction memory, buffers the
// returned words in a small queue, and presents the head to decode. A
// redirect flushes the queue; a read already in flight is drained and dropped.
module fetch_unit
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter int          DEPTH    = 2
) (
    input  logic        clk,
    input  logic        rst,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst,
    output logic [31:0] inst_pc,
    output logic [6:0]  op,
    output logic [2:0]  funct3,
    output logic [6:0]  funct7,
    input  logic        redirect,
    input  logic [31:0] redirect_target
);

    localparam int CNT_W = $clog2(DEPTH) + 1;

    fetch_state_t     state;
    logic [31:0]      fetch_pc;
    logic [31:0]      pc_plus4;
    logic [31:0]      target;
    logic [CNT_W-1:0] queue_count;
    logic [CNT_W-1:0] count_next;
    logic             fifo_full;
    logic             fifo_empty;
    logic             fire;
    logic             push;
    logic             pop;
    logic             has_room;
    fetch_entry_t     push_entry;
    fetch_entry_t     head_entry;

    // An ack only counts against a raised request; data returned while
    // draining or in a redirect cycle belongs to a stale path.
    assign fire       = imem_req & imem_ack;
    assign pop        = inst_valid & inst_ready;
    assign push       = fire & (state == FETCH) & ~redirect & (~fifo_full | pop);
    assign target     = word_align(redirect_target);
    assign pc_plus4   = fetch_pc + 32'd4;
    assign push_entry = '{inst: imem_rdata, pc: fetch_pc};
    assign has_room   = (count_next < CNT_W'(DEPTH));

    // Occupancy after this edge, used to decide whether to keep requesting.
    always_comb begin
        count_next = queue_count + CNT_W'(push) - CNT_W'(pop);
        if (redirect) count_next = '0;
    end

    inst_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (64)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .flush     (redirect),
        .head      (head_entry),
        .count     (queue_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Fetch FSM: request sequencing, redirect handling and in-flight drain.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= FETCH;
            fetch_pc  <= RESET_PC;
            imem_req  <= 1'b0;
            imem_addr <= RESET_PC;
        end else begin
            case (state)
                FETCH: begin
                    if (redirect) begin
                        fetch_pc <= target;
                        if (imem_req && !imem_ack) begin
                            // Memory still owes us a word; keep the old
                            // request up until it arrives, then drop it.
                            state <= DRAIN;
                        end else begin
                            imem_req  <= 1'b1;
                            imem_addr <= target;
                        end
                    end else if (fire) begin
                        fetch_pc  <= pc_plus4;
                        imem_req  <= has_room;
                        imem_addr <= pc_plus4;
                    end else if (!imem_req) begin
                        imem_req  <= has_room;
                        imem_addr <= fetch_pc;
                    end
                end
                DRAIN: begin
                    if (redirect) fetch_pc <= target;
                    if (imem_ack) begin
                        state     <= FETCH;
                        imem_req  <= has_room;
                        imem_addr <= redirect ? target : fetch_pc;
                    end
                end
                default: state <= FETCH;
            endcase
        end
    end

    assign inst_valid = ~fifo_empty;
    assign inst       = inst_valid ? head_entry.inst : NOP;
    assign inst_pc    = inst_valid ? head_entry.pc : fetch_pc;
    assign op         = inst[6:0];
    assign funct3     = inst[14:12];
    assign funct7     = inst[31:25];

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios with a configurable-latency
// instruction memory and an in-order scoreboard of consumed instructions.
module tb_fetch_unit;
    import riscv_pkg::*;

    localparam logic [31:0] TAG = 32'h5A5A_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic [6:0]  op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic        redirect;
    logic [31:0] redirect_target;

    logic        req_w;
    logic [31:0] addr_w;
    logic        ack_w;
    logic [31:0] rdata_w;
    logic        valid_w;
    logic        ready_w;
    logic [31:0] inst_w;
    logic [31:0] pc_w;
    logic [6:0]  op_w;
    logic [2:0]  f3_w;
    logic [6:0]  f7_w;
    logic        redirect_w;
    logic [31:0] target_w;

    int          checks = 0;
    int          errors = 0;
    int          mem_lat = 0;
    int          wait_cnt = 0;
    logic        force_ack = 1'b0;
    logic [31:0] sb_q[$];
    logic [31:0] mon_exp;

    always #5 clk = ~clk;

    fetch_unit #(.RESET_PC(32'h0000_0000), .DEPTH(2)) dut (
        .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .op(op),
        .funct3(funct3), .funct7(funct7), .redirect(redirect),
        .redirect_target(redirect_target)
    );

    fetch_unit #(.RESET_PC(32'hFFFF_FFF8), .DEPTH(2)) dut_w (
        .clk(clk), .rst(rst), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_rdata(rdata_w), .inst_valid(valid_w),
        .inst_ready(ready_w), .inst(inst_w), .inst_pc(pc_w), .op(op_w),
        .funct3(f3_w), .funct7(f7_w), .redirect(redirect_w),
        .redirect_target(target_w)
    );

    // Memory answers mem_lat cycles after a request rises; data is the address tagged.
    assign imem_ack   = (imem_req && (wait_cnt >= mem_lat)) || force_ack;
    assign imem_rdata = imem_addr ^ TAG;
    assign ack_w      = req_w;
    assign rdata_w    = addr_w ^ TAG;

    always @(posedge clk) begin
        if (!imem_req || imem_ack) wait_cnt <= 0;
        else                       wait_cnt <= wait_cnt + 1;
    end

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every decode handshake must match the next expected instruction.
    always @(negedge clk) begin
        if (inst_valid === 1'b1 && inst_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: got pc %h expected no instruction", inst_pc);
            end else begin
                mon_exp = sb_q.pop_front();
                check32("sb_pc", inst_pc, mon_exp);
                check32("sb_inst", inst, mon_exp ^ TAG);
                check32("sb_op", 32'(op), 32'(mon_exp[6:0]));
                check32("sb_funct3", 32'(funct3), 32'(mon_exp[14:12]));
                check32("sb_funct7", 32'(funct7), 32'((mon_exp ^ TAG) >> 25));
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got no completion expected finish before 100000ns");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic sb_done(input string name);
        check32(name, 32'(sb_q.size()), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        inst_ready = 1'b0;
        redirect = 1'b0;
        redirect_target = 32'h0;
        force_ack = 1'b0;
        repeat (2) step();
        @(negedge clk);
        check32("rst_req", 32'(imem_req), 32'd0);
        check32("rst_valid", 32'(inst_valid), 32'd0);
        check32("rst_inst", inst, NOP);
        check32("rst_pc", inst_pc, 32'h0000_0000);
        check32("rst_pc_w", pc_w, 32'hFFFF_FFF8);
        check32("rst_req_w", 32'(req_w), 32'd0);
        step();
        rst = 1'b0;
    endtask

    // Redirect to 0x103 while a 3-cycle read is in flight; optionally
    // redirect again to 0x203 while draining.
    task automatic drain_test(input logic second, input logic [31:0] exp_addr);
        mem_lat = 3;
        do_reset();
        sb_q.push_back(exp_addr);
        inst_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_target = 32'h0000_0103;
        @(negedge clk);
        check32("dr_req_c2", 32'(imem_req), 32'd1);
        check32("dr_addr_c2", imem_addr, 32'h0);
        step();
        redirect = second;
        redirect_target = 32'h0000_0203;
        @(negedge clk);
        check32("dr_state_c3", 32'(dut.state), 32'(DRAIN));
        check32("dr_addr_c3", imem_addr, 32'h0);
        check32("dr_valid_c3", 32'(inst_valid), 32'd0);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("dr_state_c4", 32'(dut.state), 32'(DRAIN));
        check32("dr_addr_c4", imem_addr, 32'h0);
        step();
        @(negedge clk);
        check32("dr_state_c5", 32'(dut.state), 32'(FETCH));
        check32("dr_req_c5", 32'(imem_req), 32'd1);
        check32("dr_addr_c5", imem_addr, exp_addr);
        check32("dr_valid_c5", 32'(inst_valid), 32'd0);
        repeat (4) step();
        @(negedge clk);
        check32("dr_valid_c9", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b0;
        sb_done("dr_sb_empty");
    endtask

    initial begin
        ready_w = 1'b1;
        redirect_w = 1'b0;
        target_w = 32'h0;

        // Streaming from reset, then decode stall filling the queue.
        mem_lat = 0;
        do_reset();
        for (int i = 0; i < 7; i++) sb_q.push_back(32'(i * 4));
        inst_ready = 1'b1;
        @(negedge clk);
        check32("t1_req_c0", 32'(imem_req), 32'd0);
        step();
        @(negedge clk);
        check32("t1_req_c1", 32'(imem_req), 32'd1);
        check32("t1_addr_c1", imem_addr, 32'h0);
        check32("t1_valid_c1", 32'(inst_valid), 32'd0);
        check32("wrap_addr_c1", addr_w, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check32("t1_valid_c2", 32'(inst_valid), 32'd1);
        check32("t1_addr_c2", imem_addr, 32'h4);
        check32("wrap_addr_c2", addr_w, 32'hFFFF_FFFC);
        check32("wrap_pc_c2", pc_w, 32'hFFFF_FFF8);
        step();
        @(negedge clk);
        check32("wrap_addr_c3", addr_w, 32'h0000_0000);
        check32("wrap_pc_c3", pc_w, 32'hFFFF_FFFC);
        step();
        step();
        inst_ready = 1'b0;
        step();
        @(negedge clk);
        check32("t2_req_c6", 32'(imem_req), 32'd0);
        check32("t2_count_c6", 32'(dut.queue_count), 32'd2);
        repeat (3) step();
        @(negedge clk);
        check32("t2_req_c9", 32'(imem_req), 32'd0);
        check32("t2_count_c9", 32'(dut.queue_count), 32'd2);
        check32("t2_valid_c9", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b1;
        repeat (4) step();
        inst_ready = 1'b0;
        sb_done("t2_sb_empty");

        // Redirect while a request is outstanding, with and without a second
        // redirect during the drain.
        drain_test(1'b0, 32'h0000_0100);
        drain_test(1'b1, 32'h0000_0200);

        // Redirect coinciding with an ack and a decode handshake.
        mem_lat = 0;
        do_reset();
        sb_q.push_back(32'h0);
        sb_q.push_back(32'h40);
        inst_ready = 1'b1;
        step();
        step();
        redirect = 1'b1;
        redirect_target = 32'h0000_0042;
        @(negedge clk);
        check32("co_valid_c2", 32'(inst_valid), 32'd1);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("co_valid_c3", 32'(inst_valid), 32'd0);
        check32("co_req_c3", 32'(imem_req), 32'd1);
        check32("co_addr_c3", imem_addr, 32'h40);
        step();
        @(negedge clk);
        check32("co_valid_c4", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b0;
        sb_done("co_sb_empty");

        // Redirect while the queue is full and no request is up.
        do_reset();
        sb_q.push_back(32'h80);
        step();
        step();
        step();
        redirect = 1'b1;
        redirect_target = 32'h0000_0080;
        @(negedge clk);
        check32("fu_req_c3", 32'(imem_req), 32'd0);
        check32("fu_count_c3", 32'(dut.queue_count), 32'd2);
        step();
        redirect = 1'b0;
        @(negedge clk);
        check32("fu_valid_c4", 32'(inst_valid), 32'd0);
        check32("fu_addr_c4", imem_addr, 32'h80);
        check32("fu_req_c4", 32'(imem_req), 32'd1);
        step();
        inst_ready = 1'b1;
        @(negedge clk);
        check32("fu_valid_c5", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b0;
        sb_done("fu_sb_empty");

        // Reset during a pending read; the late ack must be ignored.
        mem_lat = 3;
        do_reset();
        sb_q.push_back(32'h0);
        step();
        @(negedge clk);
        check32("rm_req_c1", 32'(imem_req), 32'd1);
        check32("rm_addr_c1", imem_addr, 32'h0);
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        force_ack = 1'b1;
        @(negedge clk);
        check32("rm_req_c3", 32'(imem_req), 32'd0);
        step();
        force_ack = 1'b0;
        inst_ready = 1'b1;
        @(negedge clk);
        check32("rm_valid_c4", 32'(inst_valid), 32'd0);
        check32("rm_req_c4", 32'(imem_req), 32'd1);
        check32("rm_addr_c4", imem_addr, 32'h0);
        repeat (4) step();
        @(negedge clk);
        check32("rm_valid_c8", 32'(inst_valid), 32'd1);
        step();
        inst_ready = 1'b0;
        sb_done("rm_sb_empty");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 The block SHALL have parameter RESET_PC, default 32'h00000000, the PC value loaded by reset.
REQ-002 The block SHALL have parameter DEPTH, default 2, the instruction queue entry count (legal values 2 and 4).
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-005 The block SHALL have port imem_req  output  1  the instruction memory read request.
REQ-006 The block SHALL have port imem_addr  output  32  the word-aligned fetch address.
REQ-007 The block SHALL have port imem_ack  input  1  asserted for one cycle when imem_rdata is valid.
REQ-008 The block SHALL have port imem_rdata  input  32  the fetched instruction word.
REQ-009 The block SHALL have port inst_valid  output  1  asserted when the queue head is presented to decode.
REQ-010 The block SHALL have port inst_ready  input  1  decode accepts the head this cycle.
REQ-011 The block SHALL have port inst  output  32  the queue head, or 32'h00000013 (NOP) when inst_valid=0.
REQ-012 The block SHALL have port inst_pc  output  32  the PC of inst.
REQ-013 The block SHALL have ports op (7), funct3 (3) and funct7 (7), all outputs, equal to inst[6:0], inst[14:12] and inst[31:25], feeding the controller.
REQ-014 The block SHALL have port redirect  input  1  asserted when the controller's PCSrc is not 2'b00.
REQ-015 The block SHALL have port redirect_target  input  32  the branch, jal or jalr target; bits [1:0] are ignored.

Function
REQ-016 The block SHALL use FSM states FETCH and DRAIN.
REQ-017 In FETCH, imem_req SHALL rise only when queue count < DEPTH, with imem_addr = fetch_pc.
REQ-018 Once raised, imem_req and imem_addr SHALL hold stable until the cycle in which imem_ack=1.
REQ-019 The block SHALL accept an ack in the same cycle that req rises (zero-wait memory).
REQ-020 On an ack in FETCH without redirect, the block SHALL push {imem_rdata, fetch_pc} and set fetch_pc = fetch_pc + 4 (modulo 2^32, so 32'hFFFFFFFC wraps to 0).
REQ-021 The block SHALL drop req for at least one cycle after each ack only if count reaches DEPTH; otherwise back-to-back requests are allowed.
REQ-022 A handshake is inst_valid & inst_ready; on a handshake the head SHALL pop.
REQ-023 A simultaneous push and pop SHALL keep count unchanged.
REQ-024 On redirect=1, the block SHALL flush all queue entries.
REQ-025 A handshake in the redirect cycle SHALL still count as consumed, since it is the redirecting instruction.
REQ-026 On redirect, the block SHALL set fetch_pc = {redirect_target[31:2], 2'b00}.
REQ-027 If redirect occurs with req outstanding and no ack that cycle, the block SHALL go to DRAIN.
REQ-028 In DRAIN, the block SHALL keep req and the old address until ack, discard the data, and then return to FETCH.
REQ-029 If redirect and ack coincide, the block SHALL discard the ack data and stay in FETCH; the next req uses the target.
REQ-030 A redirect during DRAIN SHALL update fetch_pc only.
REQ-031 inst_valid SHALL be 0 in the cycle after a redirect.
REQ-032 Latency SHALL be: redirect at cycle N -> req to target at N+1 (FETCH case) -> with zero-wait memory, inst_valid at N+2.
REQ-033 An imem_ack while imem_req=0 SHALL be ignored.

Reset
REQ-034 On rst=1 at a clock edge: fetch_pc=RESET_PC, queue empty, state=FETCH, imem_req=0, inst_valid=0, inst=NOP, inst_pc=RESET_PC.
REQ-035 Reset SHALL take priority over redirect, ack and handshake, and SHALL abandon any outstanding request without DRAIN.
REQ-036 The first req SHALL rise in the first cycle after rst deasserts.

Structure
REQ-037 Package riscv_pkg SHALL hold the NOP constant, the opcode constants (R, I-load, I-alu, jalr, S, jal, B, lui) and the PCSrc encodings (00 seq, 01 pc+imm, 10 jalr).
REQ-038 The block SHALL contain one sub-module, inst_fifo: a DEPTH-entry, 64-bit-wide synchronous FIFO with push, pop, flush, count, full and empty.

Verification
REQ-039 Reset, then zero-wait memory returning addr-as-data with inst_ready=1: inst_pc sequence SHALL be 0, 4, 8, with one instruction per cycle from cycle 2.
REQ-040 inst_ready=0 for 5 cycles: count SHALL reach 2, imem_req SHALL drop, and no instruction SHALL be lost or duplicated after ready returns.
REQ-041 3-cycle memory latency, redirect to 32'h00000103 while req is outstanding: the state SHALL enter DRAIN, the old data SHALL be discarded, and the next imem_addr SHALL be 32'h00000100.
REQ-042 Redirect coincident with ack and with a decode handshake: the head SHALL be consumed, the ack data dropped, and inst_valid=0 next cycle.
REQ-043 RESET_PC=32'hFFFFFFF8, zero-wait memory: imem_addr SHALL follow FFFFFFF8, FFFFFFFC, 00000000.
REQ-044 rst asserted mid-wait with ack arriving the following cycle: the ack SHALL be ignored, and the first post-reset fetch SHALL be at RESET_PC.
